// File: rtl/rx_packet_decoder.sv
// Decodes USB-style packets popped from the receiver FIFO: PID check, token fields with CRC5,
// data payload with CRC bytes stripped. Define RX_CRC16_CHECK_EN to also check the data CRC16.
module rx_packet_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  input  logic       rcving,
  input  logic       r_error,
  output logic       fifo_r_enable,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       tok_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_done,
  output logic       pkt_error
);

  typedef enum logic [2:0] {StIdle, StPid, StTok1, StTok2, StData, StEnd, StDrain} state_e;

  state_e      r_state;
  logic [3:0]  r_pid;
  logic        r_pid_valid;
  logic [6:0]  r_tok_addr;
  logic [3:0]  r_tok_endp;
  logic        r_tok_valid;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_pkt_done;
  logic        r_pkt_error;
  logic [7:0]  r_tok_lo;
  logic [7:0]  r_buf0;
  logic [7:0]  r_buf1;
  logic [1:0]  r_cnt;

  logic        w_pop;
  logic        w_eop;
  logic        w_pid_ok;
  logic        w_crc5_ok;
  logic        w_crc16_ok;
  logic [15:0] w_tok_word;

  // Reflected CRC5 register after shifting in the 11 token field bits, LSB first.
  function automatic logic [4:0] crc5_reg(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign w_pop = !rst && !fifo_empty &&
                 (r_state == StPid || r_state == StTok1 || r_state == StTok2 ||
                  r_state == StData || r_state == StDrain);
  assign w_eop      = !rcving && fifo_empty;
  assign w_pid_ok   = (fifo_data[7:4] == ~fifo_data[3:0]);
  assign w_tok_word = {fifo_data, r_tok_lo};
  assign w_crc5_ok  = (w_tok_word[15:11] == ~crc5_reg(w_tok_word[10:0]));

`ifdef RX_CRC16_CHECK_EN
  logic [15:0] r_crc16;

  function automatic logic [15:0] crc16_next(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'ha001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Buffer holds the trailing CRC bytes at end of packet: newest is the high byte.
  assign w_crc16_ok = ({r_buf0, r_buf1} == ~r_crc16);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc16 <= '0;
    end else if (r_state == StIdle) begin
      r_crc16 <= 16'hffff;
    end else if (r_state == StData && w_pop && !r_error && r_cnt == 2'd2) begin
      r_crc16 <= crc16_next(r_crc16, r_buf1);
    end
  end
`else
  assign w_crc16_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pid        <= '0;
      r_pid_valid  <= 1'b0;
      r_tok_addr   <= '0;
      r_tok_endp   <= '0;
      r_tok_valid  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_error  <= 1'b0;
      r_tok_lo     <= '0;
      r_buf0       <= '0;
      r_buf1       <= '0;
      r_cnt        <= '0;
    end else begin
      r_pid_valid  <= 1'b0;
      r_tok_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_error  <= 1'b0;
      if (r_state != StIdle && r_error) begin
        r_state <= StDrain;
      end else begin
        case (r_state)
          StIdle: begin
            r_cnt <= '0;
            if (!fifo_empty) r_state <= StPid;
          end
          StPid: begin
            if (w_pop) begin
              if (w_pid_ok) begin
                r_pid       <= fifo_data[3:0];
                r_pid_valid <= 1'b1;
                case (fifo_data[3:0])
                  4'h1, 4'h9, 4'h5, 4'hd: r_state <= StTok1;
                  4'h3, 4'hb:             r_state <= StData;
                  4'h2, 4'ha, 4'he:       r_state <= StEnd;
                  default:                r_state <= StDrain;
                endcase
              end else begin
                r_state <= StDrain;
              end
            end
          end
          StTok1: begin
            if (w_pop) begin
              r_tok_lo <= fifo_data;
              r_state  <= StTok2;
            end else if (w_eop) begin
              r_pkt_error <= 1'b1;
              r_state     <= StIdle;
            end
          end
          StTok2: begin
            if (w_pop) begin
              r_tok_addr <= w_tok_word[6:0];
              r_tok_endp <= w_tok_word[10:7];
              if (w_crc5_ok) begin
                r_tok_valid <= 1'b1;
                r_state     <= StEnd;
              end else begin
                r_state <= StDrain;
              end
            end else if (w_eop) begin
              r_pkt_error <= 1'b1;
              r_state     <= StIdle;
            end
          end
          StData: begin
            if (w_pop) begin
              r_buf0 <= fifo_data;
              r_buf1 <= r_buf0;
              if (r_cnt == 2'd2) begin
                r_data_out   <= r_buf1;
                r_data_valid <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 2'd1;
              end
            end else if (w_eop) begin
              if (r_cnt == 2'd2 && w_crc16_ok) r_pkt_done  <= 1'b1;
              else                             r_pkt_error <= 1'b1;
              r_state <= StIdle;
            end
          end
          StEnd: begin
            if (w_eop) begin
              r_pkt_done <= 1'b1;
              r_state    <= StIdle;
            end else if (!fifo_empty) begin
              r_state <= StDrain;
            end
          end
          StDrain: begin
            if (w_eop) begin
              r_pkt_error <= 1'b1;
              r_state     <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign fifo_r_enable = w_pop;
  assign pid           = r_pid;
  assign pid_valid     = r_pid_valid;
  assign tok_addr      = r_tok_addr;
  assign tok_endp      = r_tok_endp;
  assign tok_valid     = r_tok_valid;
  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign pkt_done      = r_pkt_done;
  assign pkt_error     = r_pkt_error;

endmodule
